// File: rtl/multi_debounce_scheduler.sv
// Multi-channel debouncer: a prescaler tick starts a round-robin scan that
// updates one channel's sample history and debounced level per clock.
module multi_debounce_scheduler #(
  parameter int unsigned CLK_FREQUENCY_HZ       = 100000000,
  parameter int unsigned DEBOUNCE_FREQUENCY_HZ  = 250,
  parameter int unsigned CNTR_WIDTH             = 32,
  parameter int unsigned NUM_INPUTS             = 8,
  parameter int unsigned HISTORY_DEPTH          = 4,
  parameter int unsigned SIMULATE               = 0,
  parameter int unsigned SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_INPUTS-1:0] signal_in,
  input  logic                  clear_overrun,
  output logic [NUM_INPUTS-1:0] signal_out,
  output logic [NUM_INPUTS-1:0] rise_pulse,
  output logic [NUM_INPUTS-1:0] fall_pulse,
  output logic                  scan_busy,
  output logic                  overrun
);

  localparam int unsigned IDX_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned HIST_W   = HISTORY_DEPTH - 1;
  localparam int unsigned TOP_FULL = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                   : CLK_FREQUENCY_HZ / DEBOUNCE_FREQUENCY_HZ - 1;
  localparam logic [CNTR_WIDTH-1:0] TOP      = CNTR_WIDTH'(TOP_FULL);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                          state_q, state_d;
  logic [CNTR_WIDTH-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_INPUTS-1:0]           sync1_q, sync2_q;
  // Only the previous D-1 samples are stored; the fresh sample completes the window.
  logic [NUM_INPUTS-1:0][HIST_W-1:0] hist_q, hist_d;
  logic [NUM_INPUTS-1:0]           signal_out_q, signal_out_d;
  logic [NUM_INPUTS-1:0]           rise_q, rise_d;
  logic [NUM_INPUTS-1:0]           fall_q, fall_d;
  logic                            scan_busy_q, scan_busy_d;
  logic                            overrun_q, overrun_d;
  logic                            tick_c;
  logic [HISTORY_DEPTH-1:0]        nh_c;

  assign signal_out = signal_out_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign scan_busy  = scan_busy_q;
  assign overrun    = overrun_q;

  assign tick_c = enable && (cnt_q == TOP);
  assign nh_c   = {hist_q[idx_q], sync2_q[idx_q]};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hist_d       = hist_q;
    signal_out_d = signal_out_q;
    rise_d       = '0;
    fall_d       = '0;
    overrun_d    = overrun_q;

    if (!enable)            cnt_d = '0;
    else if (cnt_q == TOP)  cnt_d = '0;
    else                    cnt_d = cnt_q + CNTR_WIDTH'(1);

    if (clear_overrun) overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (tick_c) state_d = SCAN;
      end
      SCAN: begin
        hist_d[idx_q] = nh_c[HIST_W-1:0];
        if ((&nh_c) && !signal_out_q[idx_q]) begin
          signal_out_d[idx_q] = 1'b1;
          rise_d[idx_q]       = 1'b1;
        end else if (!(|nh_c) && signal_out_q[idx_q]) begin
          signal_out_d[idx_q] = 1'b0;
          fall_d[idx_q]       = 1'b1;
        end
        // A tick landing mid-scan is dropped and flagged; the set beats a clear.
        if (tick_c) overrun_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    scan_busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      hist_q       <= '0;
      signal_out_q <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      scan_busy_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sync1_q      <= signal_in;
      sync2_q      <= sync1_q;
      hist_q       <= hist_d;
      signal_out_q <= signal_out_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      scan_busy_q  <= scan_busy_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_multi_debounce_scheduler.sv
// Randomized bench for multi_debounce_scheduler: a run-length debounce model
// predicts every output each clock for a slow-tick and an overrunning instance.
module tb_multi_debounce_scheduler;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int CNT_A = 15;
  localparam int CNT_B = 2;

  logic         clk = 1'b0;
  logic         reset, enable, clr_a, clr_b;
  logic [N-1:0] in_a, in_b;
  logic [N-1:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b;
  logic         busy_a, ovr_a, busy_b, ovr_b;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int k, lat, waited;
  int rise_cnt [N];
  int fall_t   [N];

  // Model state: prescaler count, scan position (-1 = idle), run-length per channel.
  int       ma_cnt, ma_pos, mb_cnt, mb_pos;
  bit [N-1:0] ma_s1, ma_s2, ma_out, ma_rise, ma_fall;
  bit       ma_ovr, mb_ovr;
  bit       ma_last [N];
  int       ma_run  [N];

  always #5 clk = ~clk;

  multi_debounce_scheduler #(
    .CNTR_WIDTH(8), .NUM_INPUTS(N), .HISTORY_DEPTH(D),
    .SIMULATE(1), .SIMULATE_FREQUENCY_CNT(CNT_A)
  ) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .signal_in(in_a),
    .clear_overrun(clr_a), .signal_out(out_a), .rise_pulse(rise_a),
    .fall_pulse(fall_a), .scan_busy(busy_a), .overrun(ovr_a)
  );

  multi_debounce_scheduler #(
    .CNTR_WIDTH(8), .NUM_INPUTS(N), .HISTORY_DEPTH(D),
    .SIMULATE(1), .SIMULATE_FREQUENCY_CNT(CNT_B)
  ) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .signal_in(in_b),
    .clear_overrun(clr_b), .signal_out(out_b), .rise_pulse(rise_b),
    .fall_pulse(fall_b), .scan_busy(busy_b), .overrun(ovr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    ma_cnt = 0; ma_pos = -1; ma_s1 = '0; ma_s2 = '0; ma_ovr = 0;
    ma_out = '0; ma_rise = '0; ma_fall = '0;
    for (int i = 0; i < N; i++) begin ma_last[i] = 0; ma_run[i] = D; end
    mb_cnt = 0; mb_pos = -1; mb_ovr = 0;
  endtask

  task automatic model_step(input bit rst, input bit en, input bit [N-1:0] ia,
                            input bit ca, input bit cb);
    bit tick_a, tick_b, s;
    bit [N-1:0] smp;
    int ch;
    if (rst) begin model_reset(); return; end
    // Instance A
    tick_a = en && (ma_cnt == CNT_A);
    ma_cnt = (!en || ma_cnt == CNT_A) ? 0 : ma_cnt + 1;
    smp = ma_s2; ma_s2 = ma_s1; ma_s1 = ia;
    ma_rise = '0; ma_fall = '0;
    if (ma_pos >= 0) begin
      ch = ma_pos;
      s  = smp[ch];
      if (s == ma_last[ch]) ma_run[ch]++;
      else begin ma_last[ch] = s; ma_run[ch] = 1; end
      if (ma_run[ch] >= D && ma_out[ch] != s) begin
        ma_out[ch] = s;
        if (s) ma_rise[ch] = 1; else ma_fall[ch] = 1;
      end
      ma_ovr = tick_a ? 1'b1 : (ca ? 1'b0 : ma_ovr);
      ma_pos = (ma_pos == N - 1) ? -1 : ma_pos + 1;
    end else begin
      if (ca) ma_ovr = 0;
      if (tick_a) ma_pos = 0;
    end
    // Instance B: only scan timing and overrun are modelled
    tick_b = en && (mb_cnt == CNT_B);
    mb_cnt = (!en || mb_cnt == CNT_B) ? 0 : mb_cnt + 1;
    if (mb_pos >= 0) begin
      mb_ovr = tick_b ? 1'b1 : (cb ? 1'b0 : mb_ovr);
      mb_pos = (mb_pos == N - 1) ? -1 : mb_pos + 1;
    end else begin
      if (cb) mb_ovr = 0;
      if (tick_b) mb_pos = 0;
    end
  endtask

  task automatic compare_all();
    check("a_signal_out", 32'(out_a),  32'(ma_out));
    check("a_rise_pulse", 32'(rise_a), 32'(ma_rise));
    check("a_fall_pulse", 32'(fall_a), 32'(ma_fall));
    check("a_scan_busy",  32'(busy_a), 32'(ma_pos >= 0));
    check("a_overrun",    32'(ovr_a),  32'(ma_ovr));
    check("b_scan_busy",  32'(busy_b), 32'(mb_pos >= 0));
    check("b_overrun",    32'(ovr_b),  32'(mb_ovr));
  endtask

  // One clock: capture inputs seen at the edge, then advance model and compare.
  task automatic cycle();
    bit r, e, ca, cb;
    bit [N-1:0] ia;
    @(posedge clk);
    r = reset; e = enable; ia = in_a; ca = clr_a; cb = clr_b;
    #1;
    cyc++;
    model_step(r, e, ia, ca, cb);
    compare_all();
    for (int i = 0; i < N; i++) begin
      if (rise_a[i]) rise_cnt[i]++;
      if (fall_a[i]) fall_t[i] = cyc;
    end
  endtask

  task automatic drive_rand();
    clr_a = ($urandom_range(15, 0) == 0);
    clr_b = ($urandom_range(3, 0) == 0);
    in_b  = N'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) begin cycle(); drive_rand(); end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin rise_cnt[i] = 0; fall_t[i] = -1; end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    in_a = '0; in_b = '0;
    model_reset();
    clear_stats();

    // T1: reset held 3 clocks, then no ticks while disabled, then first scan latency
    run(3);
    reset = 1'b0;
    run(3);
    enable = 1'b1;
    lat = 0;
    while (busy_a == 1'b0 && lat < 100) begin cycle(); drive_rand(); lat++; end
    // enable first seen at edge 1, count reaches top at edge top, SCAN entered at edge top+1
    check("t1_scan_latency", 32'(lat), 32'(CNT_A + 1));

    // T2: clean rise on channel 2
    clear_stats();
    in_a[2] = 1'b1;
    run(120);
    check("t2_rise_count_ch2", 32'(rise_cnt[2]), 32'd1);
    check("t2_level_ch2", 32'(out_a[2]), 32'd1);

    // T3: glitch on channel 1 lasting about three ticks
    clear_stats();
    in_a[1] = 1'b1;
    run(3 * (CNT_A + 1) - 4);
    in_a[1] = 1'b0;
    run(100);
    check("t3_rise_count_ch1", 32'(rise_cnt[1]), 32'd0);
    check("t3_fall_seen_ch1", 32'(fall_t[1] >= 0), 32'd0);

    // T4: ch0 and ch3 rise, then fall together outside a scan
    in_a[0] = 1'b1; in_a[3] = 1'b1;
    run(120);
    waited = 0;
    while (ma_pos != N - 1 && waited < 40) begin cycle(); drive_rand(); waited++; end
    check("t4_sync_wait", 32'(waited < 40), 32'd1);
    cycle(); drive_rand();
    clear_stats();
    in_a[0] = 1'b0; in_a[3] = 1'b0;
    run(120);
    check("t4_fall_gap", 32'(fall_t[3] - fall_t[0]), 32'd3);
    check("t4_fall_seen", 32'(fall_t[0] > 0), 32'd1);

    // T6: reset at idx 2 while channel 1 is partway to a rise
    in_a[1] = 1'b1;
    run(2 * (CNT_A + 1));
    waited = 0;
    while (ma_pos != 2 && waited < 40) begin cycle(); drive_rand(); waited++; end
    check("t6_idx_wait", 32'(waited < 40), 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_busy_now", 32'(busy_a), 32'd0);
    check("t6_out_now", 32'(out_a), 32'd0);
    check("t6_pulse_now", 32'(rise_a | fall_a), 32'd0);
    run(2);
    reset = 1'b0;
    clear_stats();
    run(4 * (CNT_A + 1));
    check("t6_no_early_rise", 32'(rise_cnt[1]), 32'd0);
    run(3 * (CNT_A + 1));
    check("t6_rise_after", 32'(rise_cnt[1]), 32'd1);

    // Random traffic: sparse level flips, glitches, enable toggles, occasional reset
    repeat (3000) begin
      cycle();
      drive_rand();
      reset = 1'b0;
      if ($urandom_range(29, 0) == 0) begin
        k = $urandom_range(N - 1, 0);
        in_a[k] = ~in_a[k];
      end
      if ($urandom_range(399, 0) == 0) enable = ~enable;
      if ($urandom_range(1499, 0) == 0) begin
        reset = 1'b1;
        model_reset();
      end
    end
    reset = 1'b0;
    enable = 1'b1;
    run(50);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
